sram_arbiter: RTL and testbench

Shares the single 16-bit external SRAM request port between the instruction-fetch and data-memory requesters and turns each 32-bit access into two sequenced 16-bit SRAM transactions. Sits between the CPU memory stage / fetch unit and the external SRAM bus controller. Drives the controller's valid/rw/addri/dtw inputs and consumes its one-cycle done pulse and dtr.

---
 rtl/sram_arb_pkg.sv | 24 ++
 rtl/sram_rr_arb2.sv | 43 ++++
 rtl/sram_arbiter.sv | 163 ++++++++++++++++
 tb/tb_sram_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_arb_pkg.sv
// Shared definitions for the SRAM arbiter: sequencing states, halfword
// offsets within a 32-bit word, requester IDs and an address helper.
package sram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    ACK  = 2'd3
  } state_t;

  localparam logic [1:0] HALF_LO = 2'b00;
  localparam logic [1:0] HALF_HI = 2'b10;

  // Requester IDs double as bit positions in the arbiter request/grant vectors.
  localparam logic REQ_IF = 1'b0;
  localparam logic REQ_D  = 1'b1;

  // Byte address of one halfword of a 32-bit word.
  function automatic logic [31:0] half_addr(input logic [29:0] word, input logic [1:0] half);
    return {word, half};
  endfunction

endpackage

// File: rtl/sram_rr_arb2.sv
// Two-input round-robin arbiter.
// Ports:
//   clk, reset   clock, async active-high reset
//   i_req[1:0]   requests, bit REQ_IF = fetch, bit REQ_D = data
//   i_upd        strobe: record the current grant as last served
//   o_grant[1:0] one-hot grant (combinational); 0 when no request
// After reset fetch counts as last served, so data wins a first tie.
import sram_arb_pkg::*;

module sram_rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] i_req,
  input  logic       i_upd,
  output logic [1:0] o_grant
);

  logic r_last;

  // Grant: on a tie the requester not served last wins.
  always_comb begin
    o_grant = 2'b00;
    if (i_req[REQ_IF] && i_req[REQ_D]) begin
      if (r_last == REQ_IF) begin
        o_grant = 2'b10;
      end else begin
        o_grant = 2'b01;
      end
    end else begin
      o_grant = i_req;
    end
  end

  // Last-served flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_last <= REQ_IF;
    end else if (i_upd && (|o_grant)) begin
      r_last <= o_grant[REQ_D];
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// Shares the 16-bit SRAM controller port between fetch and data requesters,
// splitting each 32-bit access into a low then a high halfword transaction.
// Ports:
//   clk, reset                     clock, async active-high reset
//   if_req/if_addr/if_rdata/if_ack fetch requester (read only)
//   d_req/d_we/d_addr/d_wdata      data requester
//   d_rdata/d_ack                  data response
//   mem_valid/mem_rw/mem_addr/mem_dtw  request to the SRAM controller
//   mem_dtr/mem_done               controller response
import sram_arb_pkg::*;

module sram_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ack,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_ack,
  output logic        mem_valid,
  output logic        mem_rw,
  output logic [31:0] mem_addr,
  output logic [15:0] mem_dtw,
  input  logic [15:0] mem_dtr,
  input  logic        mem_done
);

  state_t      r_state;
  state_t      w_next;
  logic [29:0] r_word;
  logic        r_we;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic        r_gnt;
  logic [1:0]  w_arb_req;
  logic [1:0]  w_gnt;
  logic        w_in_ack;
  logic        w_unused;

  // Byte-lane bits are ignored; accesses are always whole words.
  assign w_unused = ^{if_addr[1:0], d_addr[1:0]};

  assign w_in_ack = (r_state == ACK);

  // In ACK the arbiter sees only the served requester, so the last-served
  // update records it even if the other side raised req meanwhile.
  assign w_arb_req = w_in_ack ? ((r_gnt == REQ_D) ? 2'b10 : 2'b01) : {d_req, if_req};

  sram_rr_arb2 u_arb (
    .clk     (clk),
    .reset   (reset),
    .i_req   (w_arb_req),
    .i_upd   (w_in_ack),
    .o_grant (w_gnt)
  );

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (|w_gnt) begin
          w_next = LO;
        end else begin
          w_next = IDLE;
        end
      end
      LO: begin
        if (mem_done) begin
          w_next = HI;
        end else begin
          w_next = LO;
        end
      end
      HI: begin
        if (mem_done) begin
          w_next = ACK;
        end else begin
          w_next = HI;
        end
      end
      ACK:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // State register plus the latched access and read data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_word  <= 30'd0;
      r_we    <= 1'b0;
      r_wdata <= 32'd0;
      r_rdata <= 32'd0;
      r_gnt   <= REQ_IF;
    end else begin
      r_state <= w_next;
      case (r_state)
        IDLE: begin
          if (|w_gnt) begin
            r_gnt   <= w_gnt[REQ_D];
            r_word  <= w_gnt[REQ_D] ? d_addr[31:2] : if_addr[31:2];
            r_we    <= w_gnt[REQ_D] & d_we;
            r_wdata <= w_gnt[REQ_D] ? d_wdata : 32'd0;
            r_rdata <= 32'd0;
          end
        end
        LO: begin
          if (mem_done && !r_we) begin
            r_rdata[15:0] <= mem_dtr;
          end
        end
        HI: begin
          if (mem_done && !r_we) begin
            r_rdata[31:16] <= mem_dtr;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // SRAM request. valid drops in the done cycle because the controller is
  // idle then and would otherwise start a second transaction.
  always_comb begin
    mem_valid = 1'b0;
    mem_rw    = 1'b0;
    mem_addr  = 32'd0;
    mem_dtw   = 16'd0;
    case (r_state)
      LO: begin
        mem_valid = !mem_done;
        mem_rw    = r_we;
        mem_addr  = half_addr(r_word, HALF_LO);
        mem_dtw   = r_wdata[15:0];
      end
      HI: begin
        mem_valid = !mem_done;
        mem_rw    = r_we;
        mem_addr  = half_addr(r_word, HALF_HI);
        mem_dtw   = r_wdata[31:16];
      end
      default: begin
        mem_valid = 1'b0;
        mem_rw    = 1'b0;
        mem_addr  = 32'd0;
        mem_dtw   = 16'd0;
      end
    endcase
  end

  assign if_ack   = w_in_ack && (r_gnt == REQ_IF);
  assign d_ack    = w_in_ack && (r_gnt == REQ_D);
  assign if_rdata = if_ack ? r_rdata : 32'd0;
  assign d_rdata  = d_ack ? r_rdata : 32'd0;

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: SRAM controller model with a 4-cycle done pulse,
// a per-cycle timing/scoreboard model and directed access sequences.
module tb_sram_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req, d_req, d_we;
  logic [31:0] if_addr, d_addr, d_wdata;
  logic [31:0] if_rdata, d_rdata;
  logic        if_ack, d_ack;
  logic        mem_valid, mem_rw, mem_done;
  logic [31:0] mem_addr;
  logic [15:0] mem_dtw, mem_dtr;

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] sram [0:4095];
  logic        stray_req;

  always #5 clk = ~clk;

  sram_arbiter dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack),
    .mem_valid(mem_valid), .mem_rw(mem_rw), .mem_addr(mem_addr), .mem_dtw(mem_dtw),
    .mem_dtr(mem_dtr), .mem_done(mem_done)
  );

  function automatic logic [11:0] hidx(input logic [31:0] a);
    return a[12:1];
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // SRAM controller model: samples valid at the negedge while idle, returns
  // done (and read data) 4 cycles later; writes land when accepted.
  logic        ctl_busy;
  int          ctl_cnt;
  logic [31:0] ctl_addr;
  logic        ctl_rw;
  initial begin
    mem_done = 1'b0;
    mem_dtr  = 16'h0000;
    ctl_busy = 1'b0;
    ctl_cnt  = 0;
    ctl_addr = 32'h0;
    ctl_rw   = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset && !ctl_busy && mem_valid) begin
        ctl_busy = 1'b1;
        ctl_cnt  = 4;
        ctl_addr = mem_addr;
        ctl_rw   = mem_rw;
        if (mem_rw) sram[hidx(mem_addr)] = mem_dtw;
      end
      @(posedge clk);
      #1;
      if (reset) begin
        ctl_busy = 1'b0;
        mem_done = 1'b0;
      end else if (ctl_busy) begin
        ctl_cnt--;
        if (ctl_cnt == 0) begin
          mem_done = 1'b1;
          mem_dtr  = ctl_rw ? 16'h0000 : sram[hidx(ctl_addr)];
          ctl_busy = 1'b0;
        end else begin
          mem_done = 1'b0;
        end
      end else begin
        mem_done = stray_req;
      end
    end
  end

  // Reference model: offset k cycles after the grant cycle g fixes what every
  // output must be (valid 1-4 and 6-9, done 5 and 10, ack at 11, idle at 12).
  logic        m_active, m_win, m_we, m_last, m_prev_valid;
  int          m_off, m_rises;
  logic [31:0] m_addr, m_wdata, m_exp_rdata;
  logic [31:0] m_lo_addr, m_hi_addr;
  initial begin
    m_active = 1'b0; m_win = 1'b0; m_we = 1'b0; m_last = 1'b0; m_prev_valid = 1'b0;
    m_off = 0; m_rises = 0;
    m_addr = 32'h0; m_wdata = 32'h0; m_exp_rdata = 32'h0;
    m_lo_addr = 32'h0; m_hi_addr = 32'h0;
    forever begin
      @(negedge clk);
      if (reset) begin
        check1("rst_valid", mem_valid, 1'b0);
        check1("rst_if_ack", if_ack, 1'b0);
        check1("rst_d_ack", d_ack, 1'b0);
        check32("rst_addr", mem_addr, 32'h0);
        m_active = 1'b0;
        m_last = 1'b0;
        m_prev_valid = 1'b0;
      end else begin
        if (mem_done) check1("valid_in_done", mem_valid, 1'b0);
        if (m_active) begin
          m_off++;
          if (mem_valid && !m_prev_valid) m_rises++;
          if (m_off <= 10) begin
            check1("valid_window", mem_valid, (m_off inside {[1:4], [6:9]}));
            check32("mem_addr", mem_addr, (m_off <= 5) ? m_lo_addr : m_hi_addr);
            check1("mem_rw", mem_rw, m_we);
            check32("mem_dtw", {16'h0, mem_dtw},
                    {16'h0, (m_off <= 5) ? m_wdata[15:0] : m_wdata[31:16]});
            check1("busy_if_ack", if_ack, 1'b0);
            check1("busy_d_ack", d_ack, 1'b0);
          end else if (m_off == 11) begin
            check1("ack_valid", mem_valid, 1'b0);
            check1("if_ack", if_ack, !m_win);
            check1("d_ack", d_ack, m_win);
            check32("rdata", m_win ? d_rdata : if_rdata, m_exp_rdata);
            check32("valid_rises", m_rises, 32'd2);
            m_last = m_win;
          end else begin
            m_active = 1'b0;
          end
        end
        if (!m_active) begin
          check1("idle_valid", mem_valid, 1'b0);
          check1("idle_if_ack", if_ack, 1'b0);
          check1("idle_d_ack", d_ack, 1'b0);
          if (if_req || d_req) begin
            m_win = (if_req && d_req) ? !m_last : d_req;
            m_addr = m_win ? d_addr : if_addr;
            m_we = m_win ? d_we : 1'b0;
            m_wdata = m_win ? d_wdata : 32'h0;
            m_lo_addr = {m_addr[31:2], 2'b00};
            m_hi_addr = {m_addr[31:2], 2'b10};
            m_exp_rdata = m_we ? 32'h0 : {sram[hidx(m_hi_addr)], sram[hidx(m_lo_addr)]};
            m_active = 1'b1;
            m_off = 0;
            m_rises = 0;
          end
        end
      end
      m_prev_valid = mem_valid;
    end
  end

  // Single requester access; returns read data and cycles from grant to ack.
  task automatic do_access(input logic is_d, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, output logic [31:0] rdata, output int lat);
    lat = -1;
    rdata = 32'h0;
    if (is_d) begin
      d_we = we; d_addr = addr; d_wdata = wdata; d_req = 1'b1;
    end else begin
      if_addr = addr; if_req = 1'b1;
    end
    for (int i = 0; i < 60 && lat < 0; i++) begin
      @(negedge clk);
      if (is_d ? d_ack : if_ack) begin
        lat = i;
        rdata = is_d ? d_rdata : if_rdata;
      end
    end
    if (lat < 0) begin
      n_tests++; n_fail++;
      $display("FAIL ack_timeout: got no ack expected ack within 60 cycles");
    end
    @(posedge clk);
    #1;
    d_req = 1'b0;
    if_req = 1'b0;
  endtask

  logic order_q[$];

  // Both requesters raise req together; the served order is recorded.
  task automatic both_round();
    logic got;
    logic who;
    if_addr = 32'h200; d_addr = 32'h300; d_we = 1'b0;
    if_req = 1'b1; d_req = 1'b1;
    for (int k = 0; k < 2; k++) begin
      got = 1'b0;
      who = 1'b0;
      for (int i = 0; i < 60 && !got; i++) begin
        @(negedge clk);
        if (d_ack) begin got = 1'b1; who = 1'b1; end
        else if (if_ack) begin got = 1'b1; who = 1'b0; end
      end
      @(posedge clk);
      #1;
      if (!got) begin
        n_tests++; n_fail++;
        $display("FAIL both_timeout: got no ack expected ack within 60 cycles");
        if_req = 1'b0; d_req = 1'b0;
      end else begin
        order_q.push_back(who);
        if (who) d_req = 1'b0; else if_req = 1'b0;
      end
    end
  endtask

  logic [31:0] rd;
  int          lat;
  int          ack_cnt;
  logic        exp_order [0:3];

  initial begin
    reset = 1'b1;
    if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    if_addr = 32'h0; d_addr = 32'h0; d_wdata = 32'h0;
    stray_req = 1'b0;
    for (int i = 0; i < 4096; i++) sram[i] = 16'h0000;
    exp_order[0] = 1'b1; exp_order[1] = 1'b0; exp_order[2] = 1'b1; exp_order[3] = 1'b0;

    repeat (3) @(negedge clk);
    check1("reset_mem_rw", mem_rw, 1'b0);
    check32("reset_mem_dtw", {16'h0, mem_dtw}, 32'h0);
    check32("reset_if_rdata", if_rdata, 32'h0);
    check32("reset_d_rdata", d_rdata, 32'h0);
    #2 reset = 1'b0;
    @(posedge clk);
    #1;

    // Simultaneous requests: data, fetch, data, fetch.
    sram[hidx(32'h200)] = 16'hA0A0; sram[hidx(32'h202)] = 16'hA1A1;
    sram[hidx(32'h300)] = 16'hB0B0; sram[hidx(32'h302)] = 16'hB1B1;
    both_round();
    both_round();
    check32("order_len", order_q.size(), 32'd4);
    for (int i = 0; i < 4 && i < order_q.size(); i++)
      check1("rr_order", order_q[i], exp_order[i]);

    // Data write split into two halfword writes.
    do_access(1'b1, 1'b1, 32'h00001236, 32'hCAFEBABE, rd, lat);
    check32("write_latency", lat, 32'd11);
    check32("write_d_rdata", rd, 32'h0);
    check32("write_lo_half", {16'h0, sram[hidx(32'h1234)]}, 32'h0000BABE);
    check32("write_hi_half", {16'h0, sram[hidx(32'h1236)]}, 32'h0000CAFE);

    // Stray done while idle must change nothing.
    @(negedge clk);
    stray_req = 1'b1;
    @(negedge clk);
    stray_req = 1'b0;
    check1("stray_valid", mem_valid, 1'b0);
    check1("stray_rw", mem_rw, 1'b0);
    check1("stray_ack", if_ack | d_ack, 1'b0);
    repeat (2) @(negedge clk);
    check1("stray_ack_later", if_ack | d_ack, 1'b0);
    @(posedge clk);
    #1;

    // Fetch read, little-endian assembly.
    sram[hidx(32'h100)] = 16'h1111; sram[hidx(32'h102)] = 16'h2222;
    do_access(1'b0, 1'b0, 32'h00000100, 32'h0, rd, lat);
    check32("fetch_latency", lat, 32'd11);
    check32("fetch_rdata", rd, 32'h22221111);

    // Reset in the HI phase: no ack, then a normal access.
    sram[hidx(32'h400)] = 16'h5555; sram[hidx(32'h402)] = 16'h6666;
    d_we = 1'b0; d_addr = 32'h400; d_req = 1'b1;
    repeat (8) @(negedge clk);
    check1("pre_reset_hi_valid", mem_valid, 1'b1);
    check32("pre_reset_hi_addr", mem_addr, 32'h402);
    #2 reset = 1'b1;
    #1 check1("async_reset_valid", mem_valid, 1'b0);
    d_req = 1'b0;
    repeat (2) @(negedge clk);
    #2 reset = 1'b0;
    ack_cnt = 0;
    repeat (15) begin
      @(negedge clk);
      if (if_ack || d_ack) ack_cnt++;
    end
    check32("no_ack_after_reset", ack_cnt, 32'd0);
    @(posedge clk);
    #1;
    do_access(1'b1, 1'b0, 32'h00000400, 32'h0, rd, lat);
    check32("post_reset_latency", lat, 32'd11);
    check32("post_reset_rdata", rd, 32'h66665555);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
